// File: rtl/seg7_bin_display_if.sv
// Bundles the value/control inputs and the status/segment outputs of
// seg7_bin_display.
//   master : producer side (score/timer logic or bench) drives value, load,
//            blank_lz, blink_en and observes busy, done, overflow, hex.
//   slave  : display driver side.
interface seg7_bin_display_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 20
);
  logic [VALUE_W-1:0]      value;
  logic                    load;
  logic                    blank_lz;
  logic                    blink_en;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] hex;

  modport master (
    output value, load, blank_lz, blink_en,
    input  busy, done, overflow, hex
  );

  modport slave (
    input  value, load, blank_lz, blink_en,
    output busy, done, overflow, hex
  );
endinterface

// File: rtl/seg7_bin_display.sv
// Multi-digit seven-segment driver for the DE1-SoC HEX displays.
// A binary value accepted on load is converted to BCD by double-dabble
// (one add-3/shift step per cycle), then latched into the display register.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : value/load/blank_lz/blink_en in; busy/done/overflow/hex out
//                  hex is active-low, digit k at hex[7k+6:7k], bit i = segment i
module seg7_bin_display #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 20,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input logic               clk,
  input logic               reset_n,
  seg7_bin_display_if.slave bus
);

  localparam int unsigned BCD_W    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W    = $clog2(VALUE_W + 1);
  localparam int unsigned BLINK_CW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [VALUE_W-1:0]      r_shreg;
  logic [BCD_W-1:0]        r_bcd, w_bcd_adj;
  logic                    r_ovf_sticky;
  logic [CNT_W-1:0]        r_cnt;
  logic [BCD_W-1:0]        r_disp;
  logic                    r_disp_vld;
  logic                    r_overflow;
  logic [7*NUM_DIGITS-1:0] r_hex, w_hex;
  logic [BLINK_CW-1:0]     r_blink_cnt;
  logic                    r_blink_off;
  logic [BCD_W-1:0]        w_src;
  logic                    w_src_ovf;
  logic                    w_src_vld;
  logic [3:0]              w_nib;
  logic                    w_lead;

  // Active-high gfedcba pattern for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg      <= '0;
      r_bcd        <= '0;
      r_ovf_sticky <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.load) begin
          r_shreg      <= bus.value;
          r_bcd        <= '0;
          r_ovf_sticky <= 1'b0;
          r_cnt        <= CNT_W'(VALUE_W);
        end
        S_SHIFT: begin
          {r_bcd, r_shreg} <= {w_bcd_adj[BCD_W-2:0], r_shreg, 1'b0};
          r_ovf_sticky     <= r_ovf_sticky | w_bcd_adj[BCD_W-1];
          r_cnt            <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The output register is fed from the fresh BCD result during LATCH so the
  // new digits appear one cycle after done, not two.
  always_comb begin
    w_src     = (r_state == S_LATCH) ? r_bcd : r_disp;
    w_src_ovf = (r_state == S_LATCH) ? r_ovf_sticky : r_overflow;
    w_src_vld = (r_state == S_LATCH) | r_disp_vld;
    w_hex     = '1;
    w_lead    = 1'b1;
    w_nib     = '0;
    // Walk from the most significant digit down; w_lead stays set while every
    // digit seen so far is zero.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_nib  = w_src[4*(NUM_DIGITS-1-k) +: 4];
      w_lead = w_lead & (w_nib == 4'd0);
      if (w_src_ovf)
        w_hex[7*(NUM_DIGITS-1-k) +: 7] = 7'b0111111;
      else if (!(bus.blank_lz && w_lead && (k != NUM_DIGITS-1)))
        w_hex[7*(NUM_DIGITS-1-k) +: 7] = ~seg_decode(w_nib);
    end
    // Display stays dark until the first conversion after reset.
    if (!w_src_vld || (bus.blink_en && r_blink_off)) w_hex = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp     <= '0;
      r_disp_vld <= 1'b0;
      r_overflow <= 1'b0;
      r_hex      <= '1;
    end else begin
      r_hex <= w_hex;
      if (r_state == S_LATCH) begin
        r_disp     <= r_bcd;
        r_disp_vld <= 1'b1;
        r_overflow <= r_ovf_sticky;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BLINK_CW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_CW'(1);
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_LATCH);
  assign bus.overflow = r_overflow;
  assign bus.hex      = r_hex;

endmodule

// File: tb/tb_seg7_bin_display.sv
module tb_seg7_bin_display;
  localparam int unsigned ND = 6;
  localparam int unsigned VW = 20;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S9 = 7'b0010000;
  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [7*ND-1:0] ALL1    = '1;
  localparam logic [7*ND-1:0] E123456 = {S1, S2, S3, S4, S5, S6};
  localparam logic [7*ND-1:0] E42_LZ  = {BLK, BLK, BLK, BLK, S4, S2};
  localparam logic [7*ND-1:0] E42     = {S0, S0, S0, S0, S4, S2};
  localparam logic [7*ND-1:0] E0_LZ   = {BLK, BLK, BLK, BLK, BLK, S0};
  localparam logic [7*ND-1:0] E000000 = {S0, S0, S0, S0, S0, S0};
  localparam logic [7*ND-1:0] EDASH   = {DASH, DASH, DASH, DASH, DASH, DASH};
  localparam logic [7*ND-1:0] E999999 = {S9, S9, S9, S9, S9, S9};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  seg7_bin_display_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) bus ();

  seg7_bin_display #(.NUM_DIGITS(ND), .VALUE_W(VW), .BLINK_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always @(negedge clk) if (reset_n && bus.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Loads v, returns cycles from accept to done (period 1 = first after accept),
  // and leaves time at the negedge of the cycle where the new segments appear.
  task automatic do_load(input logic [VW-1:0] v, output int lat);
    @(posedge clk); #1;
    bus.value = v;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.hex !== ALL1) begin n_fail++; $display("FAIL reset_hex: got %h expected %h", bus.hex, ALL1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_convert();
    int lat;
    bus.blank_lz = 1'b0;
    do_load(20'd123456, lat);
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL conv_latency: got %0d expected 21", lat); end
    n_checks++; if (bus.hex !== E123456) begin n_fail++; $display("FAIL conv_hex: got %h expected %h", bus.hex, E123456); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL conv_overflow: got %b expected 0", bus.overflow); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL conv_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_blank_lz();
    int lat;
    bus.blank_lz = 1'b1;
    do_load(20'd42, lat);
    n_checks++; if (bus.hex !== E42_LZ) begin n_fail++; $display("FAIL lz_42: got %h expected %h", bus.hex, E42_LZ); end
    do_load(20'd0, lat);
    n_checks++; if (bus.hex !== E0_LZ) begin n_fail++; $display("FAIL lz_zero: got %h expected %h", bus.hex, E0_LZ); end
    @(posedge clk); #1;
    bus.blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.hex !== E000000) begin n_fail++; $display("FAIL lz_off_zero: got %h expected %h", bus.hex, E000000); end
  endtask

  task automatic test_overflow();
    int lat;
    bus.blank_lz = 1'b1;
    do_load(20'd1000000, lat);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    n_checks++; if (bus.hex !== EDASH) begin n_fail++; $display("FAIL ovf_hex: got %h expected %h", bus.hex, EDASH); end
    do_load(20'd999999, lat);
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL max_flag: got %b expected 0", bus.overflow); end
    n_checks++; if (bus.hex !== E999999) begin n_fail++; $display("FAIL max_hex: got %h expected %h", bus.hex, E999999); end
  endtask

  task automatic test_ignore_load();
    int base;
    bus.blank_lz = 1'b0;
    base = done_cnt;
    @(posedge clk); #1;
    bus.value = 20'd42;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.value = 20'd777;
    bus.load  = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.hex !== E999999) begin n_fail++; $display("FAIL ign_hold: got %h expected %h", bus.hex, E999999); end
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++; if (done_cnt - base !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt - base); end
    n_checks++; if (bus.hex !== E42) begin n_fail++; $display("FAIL ign_hex: got %h expected %h", bus.hex, E42); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_blink();
    logic off [16];
    int bad, viol, offs, unsteady;
    bad = 0; viol = 0; offs = 0; unsteady = 0;
    @(posedge clk); #1;
    bus.blink_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      off[i] = (bus.hex === ALL1);
      if (bus.hex !== ALL1 && bus.hex !== E42) bad++;
      if (off[i]) offs++;
    end
    for (int i = 0; i < 12; i++) if (off[i] == off[i+4]) viol++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL blink_values: got %0d odd samples expected 0", bad); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL blink_period: got %0d violations expected 0", viol); end
    n_checks++; if (offs !== 8) begin n_fail++; $display("FAIL blink_duty: got %0d off samples expected 8", offs); end
    @(posedge clk); #1;
    bus.blink_en = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.hex !== E42) unsteady++;
    end
    n_checks++; if (unsteady !== 0) begin n_fail++; $display("FAIL blink_off_steady: got %0d bad samples expected 0", unsteady); end
  endtask

  task automatic test_reset_mid();
    int base, lat;
    bus.blank_lz = 1'b0;
    @(posedge clk); #1;
    bus.value = 20'd123456;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    repeat (6) @(posedge clk);
    base = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.hex !== ALL1) begin n_fail++; $display("FAIL rst_mid_hex: got %h expected %h", bus.hex, ALL1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    n_checks++; if (done_cnt !== base) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses expected 0", done_cnt - base); end
    do_load(20'd999999, lat);
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected 21", lat); end
    n_checks++; if (bus.hex !== E999999) begin n_fail++; $display("FAIL rst_mid_hex_after: got %h expected %h", bus.hex, E999999); end
  endtask

  initial begin
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    test_reset();
    test_convert();
    test_blank_lz();
    test_overflow();
    test_ignore_load();
    test_blink();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
